refract_sched: RTL and testbench

- Single-owner scheduler for the shared combinational refraction unit (refractRay).
- Arbitrates among N_REQ shading lanes with round-robin priority.
- Holds the unit's inputs stable for RU_LAT cycles (multicycle path), captures ray + code, returns result tagged with requester id and incremented depth.
- Enforces recursion limit MAX_DEPTH; keeps saturating statistics.

---
 rtl/refract_sched.sv | 188 ++++++++++++++++++
 tb/tb_refract_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refract_sched.sv
// Round-robin single-owner scheduler for the shared multicycle refraction unit.
// Holds unit inputs for RU_LAT cycles, captures the result, enforces a recursion limit.
module refract_sched #(
  parameter int N_REQ     = 4,
  parameter int RU_LAT    = 3,
  parameter int MAX_DEPTH = 5,
  parameter int DEPTH_W   = 3,
  parameter int CNT_W     = 16,
  parameter int WIDTH     = 16,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int PT_W     = 3 * WIDTH,
  localparam int RAY_W    = 6 * WIDTH,
  localparam int TRI_W    = 9 * WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][RAY_W-1:0]      req_ray,
  input  logic [N_REQ-1:0][TRI_W-1:0]      req_trig,
  input  logic [N_REQ-1:0][PT_W-1:0]       req_ip,
  input  logic [N_REQ-1:0][PT_W-1:0]       req_normal,
  input  logic [N_REQ-1:0][31:0]           req_of,
  input  logic [N_REQ-1:0][DEPTH_W-1:0]    req_depth,
  output logic [RAY_W-1:0]                 ru_ray,
  output logic [TRI_W-1:0]                 ru_trig,
  output logic [PT_W-1:0]                  ru_ip,
  output logic [PT_W-1:0]                  ru_normal,
  output logic [31:0]                      ru_of,
  input  logic [RAY_W-1:0]                 ru_refr,
  input  logic [1:0]                       ru_code,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [RAY_W-1:0]                 rsp_ray,
  output logic [1:0]                       rsp_code,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [DEPTH_W-1:0]               rsp_depth,
  output logic                             busy,
  output logic [CNT_W-1:0]                 cnt_issued,
  output logic [CNT_W-1:0]                 cnt_tir,
  output logic [CNT_W-1:0]                 cnt_dropped
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP, DROP} state_t;

  state_t              state_r, state_s;
  logic [ID_W-1:0]     rr_r, gnt_s, idx_s;
  logic                any_s, drop_s;
  logic [3:0]          wait_r;
  logic [RAY_W-1:0]    lat_ray_r;
  logic [DEPTH_W-1:0]  lat_depth_r;
  logic [ID_W-1:0]     lat_id_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin search: reverse scan so the lane closest to rr_r wins.
  always_comb begin
    any_s = 1'b0;
    gnt_s = '0;
    idx_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_s = ID_W'((int'(rr_r) + i) % N_REQ);
      if (req_valid[idx_s]) begin
        any_s = 1'b1;
        gnt_s = idx_s;
      end else begin
        any_s = any_s;
      end
    end
    drop_s = (int'(req_depth[gnt_s]) >= MAX_DEPTH);
  end

  // Grant strobe is combinational and only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_r == IDLE && any_s) begin
      req_ready[gnt_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) state_s = drop_s ? DROP : HOLD;
        else       state_s = IDLE;
      end
      HOLD: begin
        if (wait_r == 4'd0) state_s = RESP;
        else                state_s = HOLD;
      end
      DROP:    state_s = RESP;
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: latch on grant, drive unit inputs, capture result, update statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r        <= '0;
      wait_r      <= 4'd0;
      lat_ray_r   <= '0;
      lat_depth_r <= '0;
      lat_id_r    <= '0;
      ru_ray      <= '0;
      ru_trig     <= '0;
      ru_ip       <= '0;
      ru_normal   <= '0;
      ru_of       <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_ray     <= '0;
      rsp_code    <= 2'b00;
      rsp_id      <= '0;
      rsp_depth   <= '0;
      busy        <= 1'b0;
      cnt_issued  <= '0;
      cnt_tir     <= '0;
      cnt_dropped <= '0;
    end else begin
      busy <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (any_s) begin
            lat_ray_r   <= req_ray[gnt_s];
            lat_depth_r <= req_depth[gnt_s];
            lat_id_r    <= gnt_s;
            rr_r        <= (gnt_s == ID_W'(N_REQ - 1)) ? '0 : gnt_s + ID_W'(1);
            if (!drop_s) begin
              ru_ray    <= req_ray[gnt_s];
              ru_trig   <= req_trig[gnt_s];
              ru_ip     <= req_ip[gnt_s];
              ru_normal <= req_normal[gnt_s];
              ru_of     <= req_of[gnt_s];
              wait_r    <= 4'(RU_LAT - 1);
            end else begin
              wait_r    <= wait_r;
            end
          end else begin
            rr_r <= rr_r;
          end
        end
        HOLD: begin
          if (wait_r == 4'd0) begin
            rsp_ray    <= ru_refr;
            rsp_code   <= ru_code;
            rsp_id     <= lat_id_r;
            rsp_depth  <= lat_depth_r + DEPTH_W'(1);
            rsp_valid  <= 1'b1;
            cnt_issued <= sat_inc(cnt_issued);
            if (ru_code == 2'b01) cnt_tir <= sat_inc(cnt_tir);
            else                  cnt_tir <= cnt_tir;
          end else begin
            wait_r <= wait_r - 4'd1;
          end
        end
        DROP: begin
          rsp_ray     <= lat_ray_r;
          rsp_code    <= 2'b11;
          rsp_id      <= lat_id_r;
          rsp_depth   <= lat_depth_r;
          rsp_valid   <= 1'b1;
          cnt_dropped <= sat_inc(cnt_dropped);
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
          else           rsp_valid <= 1'b1;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_refract_sched.sv
// Randomized self-checking bench for refract_sched against a transaction-level model.
module tb_refract_sched;
  localparam int N = 4;
  localparam int LAT = 3;
  localparam int RAY_W = 48;
  localparam int TRI_W = 72;
  localparam int PT_W = 24;
  localparam logic [47:0] KEY = 48'hA5A5_5A5A_F00F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N-1:0][RAY_W-1:0] req_ray = '0;
  logic [N-1:0][TRI_W-1:0] req_trig = '0;
  logic [N-1:0][PT_W-1:0] req_ip = '0, req_normal = '0;
  logic [N-1:0][31:0] req_of = '0;
  logic [N-1:0][2:0] req_depth = '0;
  logic [RAY_W-1:0] ru_ray, ru_refr, rsp_ray;
  logic [TRI_W-1:0] ru_trig;
  logic [PT_W-1:0] ru_ip, ru_normal;
  logic [31:0] ru_of;
  logic [1:0] ru_code, rsp_code, rsp_id;
  logic rsp_valid, rsp_ready = 1'b0, busy;
  logic [2:0] rsp_depth;
  logic [15:0] cnt_issued, cnt_tir, cnt_dropped;

  // Second instance for counter saturation.
  logic [1:0] v2 = '0, rdy2, id2;
  logic [1:0][RAY_W-1:0] ray2 = '0;
  logic [1:0][TRI_W-1:0] trig2 = '0;
  logic [1:0][PT_W-1:0] ip2 = '0, nrm2 = '0;
  logic [1:0][31:0] of2 = '0;
  logic [1:0][2:0] dep2 = '0;
  logic [RAY_W-1:0] ru_ray2, rsp_ray2;
  logic [TRI_W-1:0] ru_trig2;
  logic [PT_W-1:0] ru_ip2, ru_nrm2;
  logic [31:0] ru_of2;
  logic [1:0] code2;
  logic [0:0] rsp_id2;
  logic rsp_valid2, busy2;
  logic [2:0] rsp_depth2;
  logic [3:0] ci2, ct2, cd2;

  int checks = 0;
  int errors = 0;
  int rr_m = 0, issued_m = 0, tir_m = 0, dropped_m = 0;
  logic [47:0] last_ru_m = '0;

  // Behavioural stand-in for the refraction unit.
  assign ru_refr = ru_ray ^ KEY;
  assign ru_code = ru_of[1:0];

  refract_sched #(.N_REQ(N), .RU_LAT(LAT), .MAX_DEPTH(5), .DEPTH_W(3), .CNT_W(16), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ray(req_ray), .req_trig(req_trig), .req_ip(req_ip), .req_normal(req_normal),
    .req_of(req_of), .req_depth(req_depth), .ru_ray(ru_ray), .ru_trig(ru_trig),
    .ru_ip(ru_ip), .ru_normal(ru_normal), .ru_of(ru_of), .ru_refr(ru_refr),
    .ru_code(ru_code), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ray(rsp_ray),
    .rsp_code(rsp_code), .rsp_id(rsp_id), .rsp_depth(rsp_depth), .busy(busy),
    .cnt_issued(cnt_issued), .cnt_tir(cnt_tir), .cnt_dropped(cnt_dropped));

  refract_sched #(.N_REQ(2), .RU_LAT(1), .MAX_DEPTH(5), .DEPTH_W(3), .CNT_W(4), .WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
    .req_ray(ray2), .req_trig(trig2), .req_ip(ip2), .req_normal(nrm2),
    .req_of(of2), .req_depth(dep2), .ru_ray(ru_ray2), .ru_trig(ru_trig2),
    .ru_ip(ru_ip2), .ru_normal(ru_nrm2), .ru_of(ru_of2), .ru_refr(ru_ray2),
    .ru_code(2'b01), .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_ray(rsp_ray2),
    .rsp_code(code2), .rsp_id(rsp_id2), .rsp_depth(rsp_depth2), .busy(busy2),
    .cnt_issued(ci2), .cnt_tir(ct2), .cnt_dropped(cd2));

  assign id2 = {1'b0, rsp_id2};

  always #5 clk = ~clk;

  task automatic rand_lanes();
    logic [95:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      req_ray[i] = r[47:0];
      req_ip[i] = r[71:48];
      r = {$urandom(), $urandom(), $urandom()};
      req_trig[i] = r[71:0];
      req_normal[i] = r[95:72];
      req_of[i] = $urandom();
      req_depth[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic model_reset();
    rr_m = 0; issued_m = 0; tir_m = 0; dropped_m = 0; last_ru_m = '0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (req_ready !== 4'd0 || rsp_valid !== 1'b0 || rsp_ray !== 48'd0 || rsp_code !== 2'd0 ||
        rsp_id !== 2'd0 || rsp_depth !== 3'd0 || busy !== 1'b0 || ru_ray !== 48'd0 ||
        ru_of !== 32'd0 || cnt_issued !== 16'd0 || cnt_tir !== 16'd0 || cnt_dropped !== 16'd0) begin
      errors++;
      $display("FAIL %s got rdy=%h v=%b ray=%h code=%h id=%h dep=%h busy=%b ru=%h ci=%0d want all zero",
               tag, req_ready, rsp_valid, rsp_ray, rsp_code, rsp_id, rsp_depth, busy, ru_ray, cnt_issued);
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the DUT idle.
  task automatic do_txn(input logic [3:0] mask, input int delay, input bit hold_hi);
    int g, lat, l;
    bit drop, seen;
    logic [47:0] exp_ray, in_ray;
    logic [31:0] in_of;
    logic [1:0] exp_code;
    logic [2:0] exp_depth;
    g = -1;
    for (int k = 0; k < N; k++) begin
      l = (rr_m + k) % N;
      if (g < 0 && mask[l]) g = l;
    end
    req_valid = mask;
    rsp_ready = hold_hi;
    #1;
    checks++;
    if (req_ready !== 4'(1 << g)) begin
      errors++; $display("FAIL grant got %b want %b", req_ready, 4'(1 << g));
    end
    in_ray = req_ray[g];
    in_of = req_of[g];
    drop = (req_depth[g] >= 3'd5);
    exp_ray = drop ? in_ray : (in_ray ^ KEY);
    exp_code = drop ? 2'b11 : in_of[1:0];
    exp_depth = drop ? req_depth[g] : req_depth[g] + 3'd1;
    rr_m = (g + 1) % N;
    if (drop) dropped_m++;
    else begin
      issued_m++;
      if (in_of[1:0] == 2'b01) tir_m++;
      last_ru_m = in_ray;
    end
    @(posedge clk);
    lat = 0; seen = 0;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1;
      else begin
        checks++;
        if (req_ready !== 4'd0 || busy !== 1'b1 || (!drop && (ru_ray !== in_ray || ru_of !== in_of))) begin
          errors++;
          $display("FAIL hold got rdy=%b busy=%b ru=%h want rdy=0 busy=1 ru=%h", req_ready, busy, ru_ray, in_ray);
        end
      end
    end
    checks++;
    if (!seen || lat != (drop ? 2 : LAT + 1)) begin
      errors++; $display("FAIL latency got %0d want %0d", lat, drop ? 2 : LAT + 1);
    end
    checks++;
    if (rsp_ray !== exp_ray || rsp_code !== exp_code || rsp_id !== 2'(g) || rsp_depth !== exp_depth) begin
      errors++;
      $display("FAIL rsp got ray=%h code=%h id=%0d dep=%0d want ray=%h code=%h id=%0d dep=%0d",
               rsp_ray, rsp_code, rsp_id, rsp_depth, exp_ray, exp_code, g, exp_depth);
    end
    checks++;
    if (cnt_issued !== 16'(issued_m) || cnt_tir !== 16'(tir_m) || cnt_dropped !== 16'(dropped_m) ||
        ru_ray !== last_ru_m) begin
      errors++;
      $display("FAIL counters got %0d/%0d/%0d ru=%h want %0d/%0d/%0d ru=%h", cnt_issued, cnt_tir,
               cnt_dropped, ru_ray, issued_m, tir_m, dropped_m, last_ru_m);
    end
    for (int c = 0; c < delay; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_ray !== exp_ray || rsp_code !== exp_code || req_ready !== 4'd0) begin
        errors++;
        $display("FAIL stall got v=%b ray=%h code=%h rdy=%b want v=1 ray=%h code=%h rdy=0",
                 rsp_valid, rsp_ray, rsp_code, req_ready, exp_ray, exp_code);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL release got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
    if (!hold_hi) begin
      rsp_ready = 1'b0;
      req_valid = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    rand_lanes();
    req_depth[2] = 3'd1;
    req_of[2][1:0] = 2'b00;
    do_txn(4'b0100, 0, 1'b0);
  endtask

  task automatic test_drop();
    rand_lanes();
    for (int i = 0; i < N; i++) req_depth[i] = 3'd5;
    do_txn(4'b1000, 2, 1'b0);
  endtask

  task automatic test_tir();
    rand_lanes();
    for (int i = 0; i < N; i++) begin
      req_depth[i] = 3'd2;
      req_of[i][1:0] = 2'b01;
    end
    do_txn(4'b0011, 10, 1'b0);
  endtask

  task automatic test_reset_hold();
    int bad;
    rand_lanes();
    req_depth[1] = 3'd1;
    req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    model_reset();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL post_reset_rsp got %0d valid cycles want 0", bad);
    end
    rand_lanes();
    do_txn(4'hF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    rand_lanes();
    for (int t = 0; t < 8; t++) begin
      rand_lanes();
      for (int i = 0; i < N; i++) req_depth[i] = 3'($urandom_range(0, 4));
      do_txn(4'hF, 0, 1'b1);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int t = 0; t < 30; t++) begin
      rand_lanes();
      m = 4'($urandom_range(1, 15));
      do_txn(m, $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_saturation();
    int hs, cyc, exp_c;
    v2 = 2'b01;
    hs = 0; cyc = 0;
    while (hs < 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid2) begin
        hs++;
        exp_c = (hs > 15) ? 15 : hs;
        checks++;
        if (ci2 !== 4'(exp_c) || id2 !== 2'd0) begin
          errors++; $display("FAIL sat_step got %0d id=%0d want %0d id=0", ci2, id2, exp_c);
        end
      end
    end
    v2 = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (hs != 20 || ci2 !== 4'd15 || ct2 !== 4'd15 || cd2 !== 4'd0) begin
      errors++;
      $display("FAIL saturation got hs=%0d ci=%0d ct=%0d cd=%0d want 20 15 15 0", hs, ci2, ct2, cd2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_tir();
    test_reset_hold();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
